// File: rtl/serial_bus_pkg.sv
// Shared types and sizing helpers for the serial bus arbiter.
package serial_bus_pkg;

  localparam int unsigned DEF_MASTER_NO = 2;
  localparam int unsigned DEF_SLAVE_NO  = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    BUSY      = 2'd2,
    SPLIT_REL = 2'd3
  } arb_state_t;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr.
module rr_picker #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  always_comb begin : pick
    int unsigned j;
    logic        found;
    gnt   = '0;
    idx   = '0;
    j     = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr) + i) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin serial bus arbiter with a single outstanding split transaction.
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int unsigned MASTER_NO     = DEF_MASTER_NO,
  parameter int unsigned SLAVE_NO      = DEF_SLAVE_NO,
  parameter int unsigned GRANT_TIMEOUT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [MASTER_NO-1:0]              bus_req,
  input  logic [MASTER_NO-1:0]              bus_util,
  input  logic [SLAVE_NO-1:0]               s_split_req,
  input  logic [SLAVE_NO-1:0]               s_split_done,
  output logic [MASTER_NO-1:0]              bus_grant,
  output logic [MASTER_NO-1:0]              split_en,
  output logic [sel_width(MASTER_NO)-1:0]   m_sel,
  output logic                              bus_busy,
  output logic                              split_pending
);

  localparam int unsigned MW = sel_width(MASTER_NO);
  localparam int unsigned SW = sel_width(SLAVE_NO);
  localparam int unsigned TW = sel_width(GRANT_TIMEOUT);

  arb_state_t           state_q, state_d;
  logic [MASTER_NO-1:0] grant_q, grant_d;
  logic [MASTER_NO-1:0] split_en_q, split_en_d;
  logic [MW-1:0]        sel_q, sel_d;
  logic [MW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 split_pending_q, split_pending_d;
  logic [MW-1:0]        split_master_q, split_master_d;
  logic [SW-1:0]        split_slave_q, split_slave_d;
  logic                 resume_q, resume_d;

  logic [MASTER_NO-1:0] split_master_oh;
  logic [MASTER_NO-1:0] req_eligible;
  logic [MASTER_NO-1:0] pick_gnt;
  logic [MW-1:0]        pick_idx;
  logic [MW-1:0]        next_ptr;
  logic                 resume_win;
  logic                 timer_last;

  function automatic logic [SW-1:0] lowest_set(input logic [SLAVE_NO-1:0] v);
    lowest_set = '0;
    for (int unsigned i = SLAVE_NO; i > 0; i--) begin
      if (v[i-1]) lowest_set = SW'(i - 1);
    end
  endfunction

  assign split_master_oh = {{(MASTER_NO-1){1'b0}}, 1'b1} << split_master_q;
  assign req_eligible    = bus_req & ~(split_pending_q ? split_master_oh : '0);
  assign resume_win      = resume_q && bus_req[split_master_q];
  assign next_ptr        = (sel_q == MW'(MASTER_NO - 1)) ? '0 : sel_q + MW'(1);
  assign timer_last      = (timer_q == TW'(GRANT_TIMEOUT - 1));

  rr_picker #(
    .N (MASTER_NO),
    .W (MW)
  ) u_rr_picker (
    .req (req_eligible),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    split_en_d      = '0;
    sel_d           = sel_q;
    rr_ptr_d        = rr_ptr_q;
    timer_d         = timer_q;
    split_pending_d = split_pending_q;
    split_master_d  = split_master_q;
    split_slave_d   = split_slave_q;
    resume_d        = resume_q;

    // Done capture sits before the FSM so the resume-clear in GRANT takes precedence.
    if (split_pending_q && s_split_done[split_slave_q]) resume_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (resume_win) begin
          sel_d   = split_master_q;
          grant_d = split_master_oh;
          timer_d = '0;
          state_d = GRANT;
        end else if (|req_eligible) begin
          sel_d   = pick_idx;
          grant_d = pick_gnt;
          timer_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus_util[sel_q]) begin
          state_d = BUSY;
          if (split_pending_q && resume_q && (sel_q == split_master_q)) begin
            split_pending_d = 1'b0;
            resume_d        = 1'b0;
          end
        end else if (!bus_req[sel_q] || timer_last) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      BUSY: begin
        if (!bus_util[sel_q]) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else if (|s_split_req && !split_pending_q) begin
          split_slave_d   = lowest_set(s_split_req);
          split_master_d  = sel_q;
          split_pending_d = 1'b1;
          split_en_d      = grant_q;
          grant_d         = '0;
          state_d         = SPLIT_REL;
        end
      end
      SPLIT_REL: begin
        if (!bus_util[sel_q]) begin
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      split_en_q      <= '0;
      sel_q           <= '0;
      rr_ptr_q        <= '0;
      timer_q         <= '0;
      split_pending_q <= 1'b0;
      split_master_q  <= '0;
      split_slave_q   <= '0;
      resume_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      split_en_q      <= split_en_d;
      sel_q           <= sel_d;
      rr_ptr_q        <= rr_ptr_d;
      timer_q         <= timer_d;
      split_pending_q <= split_pending_d;
      split_master_q  <= split_master_d;
      split_slave_q   <= split_slave_d;
      resume_q        <= resume_d;
    end
  end

  assign bus_grant     = grant_q;
  assign split_en      = split_en_q;
  assign m_sel         = sel_q;
  assign bus_busy      = (state_q == GRANT) || (state_q == BUSY);
  assign split_pending = split_pending_q;

endmodule
